// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_pkg                                                                   |
// | Shared defaults and pointer helper for the FIFO read/write sides.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fifo_pkg;

    localparam int DEF_N      = 3;
    localparam int DEF_SIZE   = 8;
    localparam int DEF_WIDTH  = 8;
    localparam int OBUF_DEPTH = 3;

    // Wraps at an arbitrary size, not only at a power of two.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned size);
        return (ptr == size - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_read_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_read_port_if                                                          |
// | FIFO status/storage read signals plus the downstream valid/ready port.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fifo_read_port_if
    import fifo_pkg::*;
#(
    parameter int n     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
);
    logic             fifo_empty;
    logic [WIDTH-1:0] rd_data;
    logic             read;
    logic [n-1:0]     read_addr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        input  fifo_empty, rd_data, out_ready,
        output read, read_addr, out_valid, out_data
    );

    modport slave (
        output fifo_empty, rd_data, out_ready,
        input  read, read_addr, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/fifo_out_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_out_buf                                                               |
// | Three-entry circular buffer absorbing the storage read latency.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [1:0]       occ,
    output logic      [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] r_mem [OBUF_DEPTH];
    logic [1:0]       r_head;
    logic [1:0]       r_tail;
    logic [1:0]       r_occ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (push) begin
                r_mem[r_tail] <= push_data;
                r_tail        <= 2'(ptr_inc(32'(r_tail), OBUF_DEPTH));
            end
            if (pop) begin
                r_head <= 2'(ptr_inc(32'(r_head), OBUF_DEPTH));
            end
            r_occ <= r_occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign occ       = r_occ;
    assign head_data = r_mem[r_head];

endmodule
`default_nettype wire

// File: rtl/fifo_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_read_port                                                             |
// | Credit-based pop controller feeding a full-throughput valid/ready output.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_read_port
    import fifo_pkg::*;
#(
    parameter int n     = DEF_N,
    parameter int SIZE  = DEF_SIZE,
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fifo_read_port_if.master  bus
);

    logic [n-1:0]     r_rp;
    logic             r_inf;
    logic [1:0]       w_occ;
    logic [2:0]       w_credit_used;
    logic             w_read;
    logic             w_valid;
    logic             w_deq;
    logic [WIDTH-1:0] w_head_data;

    // Words already buffered plus the one in flight must leave room for another.
    assign w_credit_used = {1'b0, w_occ} + {2'b00, r_inf};
    assign w_read        = rst & ~bus.fifo_empty & (w_credit_used < 3'(OBUF_DEPTH));
    assign w_valid       = (w_occ != 2'd0);
    assign w_deq         = w_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rp  <= '0;
            r_inf <= 1'b0;
        end else begin
            r_inf <= w_read;
            if (w_read) begin
                r_rp <= n'(ptr_inc(32'(r_rp), SIZE));
            end
        end
    end

    fifo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inf),
        .push_data (bus.rd_data),
        .pop       (w_deq),
        .occ       (w_occ),
        .head_data (w_head_data)
    );

    assign bus.read      = w_read;
    assign bus.read_addr = r_rp;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_head_data;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_read_port                                                          |
// | Directed bench with a FIFO status/storage model and output scoreboard.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fifo_read_port;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_read_port_if #(.n(3), .WIDTH(8)) bus ();

    fifo_read_port #(.n(3), .SIZE(8), .WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // FIFO storage + status model; hold masks the status so words can be preloaded.
    logic [7:0] mem [8];
    logic [2:0] wp;
    int         count;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       hold    = 1'b0;

    assign bus.fifo_empty = (count == 0) || hold;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp          <= 3'd0;
            count       <= 0;
            bus.rd_data <= 8'h00;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= wp + 3'd1;
            end
            count <= count + int'(wr_en) - int'(bus.read);
            if (bus.read) bus.rd_data <= mem[bus.read_addr];
        end
    end

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];
    logic [2:0] addr_log [$];
    logic       s_read, s_valid;
    logic [2:0] s_addr;
    logic [7:0] s_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: sample mid-cycle, score any transfer, return just after the edge.
    task automatic tick();
        @(negedge clk);
        s_read  = bus.read;
        s_addr  = bus.read_addr;
        s_valid = bus.out_valid;
        s_data  = bus.out_data;
        chk("no_read_when_empty", {31'b0, bus.read & bus.fifo_empty}, 32'd0);
        if (bus.read) addr_log.push_back(bus.read_addr);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("sb_extra_word", {31'b0, exp_q.size() != 0}, 32'd1);
            else                   chk("sb_data", {24'b0, bus.out_data}, {24'b0, exp_q.pop_front()});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        wr_en = 1'b0;
        hold  = 1'b0;
        rst   = 1'b0;
        exp_q.delete();
        addr_log.delete();
        tick();
        rst = 1'b1;
    endtask

    task automatic preload(input logic [7:0] base, input int num);
        hold = 1'b1;
        for (int i = 0; i < num; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
            exp_q.push_back(wr_data);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        chk("drain_complete", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.out_ready = 1'b0;

        // Reset state and idle hold with an empty FIFO
        #1;
        chk("rst_read",      {31'b0, bus.read},      32'd0);
        chk("rst_read_addr", {29'b0, bus.read_addr}, 32'd0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  {24'b0, bus.out_data},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_read",  {31'b0, s_read},  32'd0);
            chk("idle_valid", {31'b0, s_valid}, 32'd0);
            chk("idle_addr",  {29'b0, s_addr},  32'd0);
            chk("idle_data",  {24'b0, s_data},  32'd0);
        end

        // Single word into an empty FIFO
        bus.out_ready = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        exp_q.push_back(8'hA5);
        tick();
        chk("single_pre_read", {31'b0, s_read}, 32'd0);
        wr_en = 1'b0;
        tick();
        chk("single_T_read", {31'b0, s_read}, 32'd1);
        chk("single_T_addr", {29'b0, s_addr}, 32'd0);
        tick();
        chk("single_T1_read",  {31'b0, s_read},  32'd0);
        chk("single_T1_valid", {31'b0, s_valid}, 32'd0);
        tick();
        chk("single_T2_valid", {31'b0, s_valid}, 32'd1);
        chk("single_T2_data",  {24'b0, s_data},  32'hA5);
        tick();
        chk("single_T3_valid", {31'b0, s_valid}, 32'd0);

        // Eight preloaded words at full throughput
        reset_all();
        bus.out_ready = 1'b1;
        preload(8'h01, 8);
        hold = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("burst_read", {31'b0, s_read}, {31'b0, i < 8});
            if (i < 8) chk("burst_addr", {29'b0, s_addr}, 32'(i));
            chk("burst_valid", {31'b0, s_valid}, {31'b0, (i >= 2) && (i < 10)});
        end
        chk("burst_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: only three pops, head held, then ordered release
        reset_all();
        bus.out_ready = 1'b0;
        preload(8'h10, 8);
        hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("stall_read", {31'b0, s_read}, {31'b0, i < 3});
            if (i >= 2) begin
                chk("stall_valid", {31'b0, s_valid}, 32'd1);
                chk("stall_data",  {24'b0, s_data},  32'h10);
            end
        end
        chk("stall_read_count", 32'(addr_log.size()), 32'd3);
        bus.out_ready = 1'b1;
        drain();

        // Twelve words streamed across the read pointer wrap
        reset_all();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h20 + 8'(i);
            exp_q.push_back(wr_data);
            tick();
        end
        wr_en = 1'b0;
        drain();
        chk("wrap_read_count", 32'(addr_log.size()), 32'd12);
        for (int i = 0; i < 12 && i < addr_log.size(); i++) begin
            chk("wrap_addr", {29'b0, addr_log[i]}, 32'(i % 8));
        end

        // Reset while two words are buffered and one is in flight
        reset_all();
        bus.out_ready = 1'b0;
        preload(8'h40, 4);
        hold = 1'b0;
        tick();
        tick();
        tick();
        chk("midrst_pre_valid", {31'b0, s_valid}, 32'd1);
        chk("midrst_pre_read",  {31'b0, s_read},  32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_addr",  {29'b0, bus.read_addr}, 32'd0);
        chk("midrst_read",  {31'b0, bus.read},      32'd0);
        chk("midrst_data",  {24'b0, bus.out_data},  32'd0);
        exp_q.delete();
        addr_log.delete();
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        exp_q.push_back(8'h55);
        tick();
        wr_data = 8'h66;
        exp_q.push_back(8'h66);
        tick();
        wr_en = 1'b0;
        drain();
        chk("midrst_read_count", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() >= 2) begin
            chk("midrst_first_addr",  {29'b0, addr_log[0]}, 32'd0);
            chk("midrst_second_addr", {29'b0, addr_log[1]}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
